// File: rtl/d_flip_flop_pkg.sv
// Shared limits and defaults for the d_flip_flop register pipeline.
// Imported by d_flip_flop and dff_stage.
package d_flip_flop_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 8;

    // Wide enough for any legal WIDTH; instances slice it down to their own width.
    localparam logic [MAX_WIDTH-1:0] DEFAULT_RST_VAL = '0;

endpackage : d_flip_flop_pkg

// File: rtl/dff_stage.sv
// One WIDTH-bit register with asynchronous active-high reset and a clock enable.
// The enable is tied high by the parent when clock gating is not built in.
module dff_stage
    import d_flip_flop_pkg::*;
#(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = DEFAULT_RST_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        // NOTE: default to the held value first so no path leaves data_d unassigned (no latch).
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : dff_stage

// File: rtl/d_flip_flop.sv
// Parameterised D register pipeline of STAGES dff_stage instances, qout straight from the last one.
// Optional clock enable port en is built when D_FLIP_FLOP_CE_EN is defined.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int                WIDTH   = 1,
    parameter int                STAGES  = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = DEFAULT_RST_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    input  logic             rst,
    output logic [WIDTH-1:0] qout
`ifdef D_FLIP_FLOP_CE_EN
    ,
    input  logic             en
`endif
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("d_flip_flop: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("d_flip_flop: STAGES %0d outside 1..%0d", STAGES, MAX_STAGES);
    end

    logic stage_en;

`ifdef D_FLIP_FLOP_CE_EN
    assign stage_en = en;
`else
    assign stage_en = 1'b1;
`endif

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] stage_in;

        if (g == 0) begin : g_first
            assign stage_in = d;
        end else begin : g_chain
            assign stage_in = stage_q[g-1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (stage_en),
            .d_i  (stage_in),
            .q_o  (stage_q[g])
        );
    end

    assign qout = stage_q[STAGES-1];

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit single-stage instance and an 8-bit three-stage one with RST_VAL 0xA5.
// The clock-enable checks are compiled in when D_FLIP_FLOP_CE_EN is defined.
module tb_d_flip_flop;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1;
    logic [7:0] d3;
    logic       q1;
    logic [7:0] q3;
    logic       en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    d_flip_flop #(
        .WIDTH  (1),
        .STAGES (1)
    ) u_dut1 (
        .clk  (clk),
        .d    (d1),
        .rst  (rst),
        .qout (q1)
`ifdef D_FLIP_FLOP_CE_EN
        ,
        .en   (en)
`endif
    );

    d_flip_flop #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'hA5)
    ) u_dut3 (
        .clk  (clk),
        .d    (d3),
        .rst  (rst),
        .qout (q3)
`ifdef D_FLIP_FLOP_CE_EN
        ,
        .en   (en)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_d3  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] seq_q3  [6] = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44};
    logic       seq_d1  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        d1  = 1'b0;
        d3  = 8'h00;
        en  = 1'b1;

        #1;
        check("reset_q1", q1, 0);
        check("reset_q3", q3, 64'hA5);

        d1 = 1'b1;
        d3 = 8'hFF;
        tick();
        check("clk_in_reset_q1", q1, 0);
        check("clk_in_reset_q3", q3, 64'hA5);

        rst = 1'b0;
        d1  = 1'b0;
        d3  = 8'h3C;
        tick();
        check("first_edge_q1", q1, 0);
        check("lat_e1_q3", q3, 64'hA5);

        d1 = 1'b1;
        #6;
        check("no_change_before_edge", q1, 0);
        tick();
        check("load_one_q1", q1, 1);
        check("lat_e2_q3", q3, 64'hA5);

        tick();
        check("lat_e3_q3", q3, 64'h3C);
        check("hold_one_q1", q1, 1);

        // Short reset pulse wholly between two edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q1", q1, 0);
        check("async_rst_q3", q3, 64'hA5);
        #4;
        rst = 1'b0;
        check("rst_hold_q1", q1, 0);
        tick();
        check("after_pulse_q1", q1, 1);
        check("flush_q3", q3, 64'hA5);

        for (int i = 0; i < 6; i++) begin
            d1 = seq_d1[i];
            d3 = seq_d3[i];
            tick();
            check($sformatf("pipe_q3_%0d", i), q3, seq_q3[i]);
            check($sformatf("pipe_q1_%0d", i), q1, seq_d1[i]);
        end

        d1 = 1'b0;
        tick();
        check("glitch_base_q1", q1, 0);
        #2 d1 = 1'b1;
        #2 d1 = 1'b0;
        tick();
        check("glitch_low_q1", q1, 0);
        d1 = 1'b1;
        tick();
        check("glitch_pre_q1", q1, 1);
        #2 d1 = 1'b0;
        #2 d1 = 1'b1;
        tick();
        check("glitch_high_q1", q1, 1);

        // Reset rising on the same edge that would load d.
        d1 = 1'b0;
        d3 = 8'h77;
        tick();
        check("pre_coincide_q1", q1, 0);
        d1 = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("coincide_q1", q1, 0);
        check("coincide_q3", q3, 64'hA5);
        #3;
        rst = 1'b0;

`ifdef D_FLIP_FLOP_CE_EN
        d3 = 8'h0F;
        d1 = 1'b1;
        en = 1'b1;
        tick();
        tick();
        tick();
        check("ce_setup_q3", q3, 64'h0F);
        check("ce_setup_q1", q1, 1);

        en = 1'b0;
        d3 = 8'hF0;
        d1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ce_hold_q3_%0d", i), q3, 64'h0F);
            check($sformatf("ce_hold_q1_%0d", i), q1, 1);
        end

        en = 1'b1;
        tick();
        check("ce_run_e1_q3", q3, 64'h0F);
        check("ce_run_e1_q1", q1, 0);
        tick();
        check("ce_run_e2_q3", q3, 64'h0F);
        tick();
        check("ce_run_e3_q3", q3, 64'hF0);

        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ce_rst_q3", q3, 64'hA5);
        tick();
        check("ce_rst_clk_q3", q3, 64'hA5);
        rst = 1'b0;
        en  = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_d_flip_flop

// File: doc/d_flip_flop.md
D_FLIP_FLOP -- requirements
Module: d_flip_flop

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 1: data width in bits, legal range 1..64.
REQ-003 Parameter STAGES, default 1: number of register stages between d and qout, legal range 1..8.
REQ-004 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into every stage on reset.
REQ-005 clk  input  1  rising-edge clock for all stages.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 d  input  WIDTH  data sampled at each rising clk edge.
REQ-008 qout  output  WIDTH  last-stage contents.
REQ-009 Positional port order SHALL be clk, d, rst, qout, followed by en when D_FLIP_FLOP_CE_EN is defined.

Function
REQ-010 On each rising clk edge with rst low (and en high when enabled), stage 0 SHALL load d and stage k SHALL load stage k-1.
REQ-011 qout SHALL equal the value d held STAGES rising edges earlier; latency is STAGES cycles.
REQ-012 With STAGES=1 the block SHALL behave as a plain edge-triggered D register: qout changes only after a rising edge.
REQ-013 qout SHALL be driven directly from a register, with no combinational path from d or en to qout.
REQ-014 Changes on d between clock edges SHALL have no effect on qout.
REQ-015 The STAGES and WIDTH checks SHALL fail elaboration for values outside their legal ranges.

Reset
REQ-016 When rst goes high, every stage and qout SHALL take RST_VAL immediately, without waiting for a clk edge.
REQ-017 While rst is high, clock edges SHALL be ignored and qout SHALL hold RST_VAL.
REQ-018 If rst and a rising clk edge coincide, reset SHALL win.
REQ-019 After rst falls, the first rising edge SHALL load d normally; a reset pulse mid-pipeline SHALL discard all in-flight data.

Configuration
REQ-020 Macro D_FLIP_FLOP_CE_EN defined: the block SHALL add input en (1 bit), and all stages SHALL hold their value when en is low on a rising edge.
REQ-021 Macro D_FLIP_FLOP_CE_EN undefined: the en port SHALL be absent, and all stages SHALL load on every rising edge.
REQ-022 Reset behaviour SHALL be identical with and without the macro, and en SHALL be ignored while rst is high.

Structure
REQ-023 Package d_flip_flop_pkg SHALL hold the constants MAX_WIDTH=64, MAX_STAGES=8 and DEFAULT_RST_VAL=0.
REQ-024 Sub-module dff_stage SHALL implement one WIDTH-bit register with async reset and optional enable, instantiated STAGES times via generate.

Verification
REQ-025 WIDTH=1, STAGES=1, clk period 10 ns, rst low: d=0 then d=1 at 10 ns -> qout=1 after the first rising edge following 10 ns.
REQ-026 rst pulses high for 5 ns between clock edges while qout=1 -> qout=0 within the pulse, before any clk edge; qout=d after the next edge once rst is low.
REQ-027 STAGES=3, WIDTH=8: drive d=0x11,0x22,0x33,0x44 on consecutive edges -> qout=0x11 exactly 3 edges after 0x11 is sampled, and the sequence is preserved.
REQ-028 RST_VAL=0xA5, WIDTH=8: assert rst -> qout=0xA5 immediately; release rst with d=0x3C -> qout=0x3C after STAGES edges.
REQ-029 D_FLIP_FLOP_CE_EN defined, qout=0x0F: en=0 for 4 edges with d=0xF0 -> qout stays 0x0F; en=1 -> qout=0xF0 after STAGES edges.
REQ-030 d toggles 0->1->0 wholly between two edges -> qout unchanged at the following edge relative to the value of d sampled at that edge.
